piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out transmitter; converts a captured N-bit word into a bit stream, one bit per accepted cycle.
- It is the send-side counterpart of the team's parallel `register` capture path.
- It sits between a parallel data source, which uses a valid/ready load handshake, and a serial sink, which uses a valid/ready bit handshake.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- MSB_FIRST, 1, 1 = bit N-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- D  input  N  parallel word to transmit; sampled only on an accepted load.
- load_valid  input  1  source has a word on D.
- load_ready  output  1  block can accept a word (high only in IDLE).
- s_data  output  1  current serial bit.
- s_valid  output  1  s_data is valid (high only in SHIFT).
- s_ready  input  1  sink accepts s_data this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - Outputs: load_ready=1, s_valid=0, s_data=0, busy=0, done=0.
  - Release is synchronous to clk.
- States: IDLE, SHIFT, DONE. Encoding is a shared enum.
- IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1: capture D into shift_reg, clear cnt, go to SHIFT.
  - load_valid=0: stay in IDLE.
- SHIFT:
  - s_valid=1.
  - s_data = shift_reg[N-1] if MSB_FIRST=1, else shift_reg[0].
  - On an edge with s_ready=1:
    - Shift by one toward the output end, zero-filling the vacated bit.
    - If cnt==N-1: go to DONE.
    - Otherwise: cnt<=cnt+1.
  - With s_ready=0: shift_reg, cnt and s_data all hold.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - s_valid=0, s_data=0, load_ready=0.
  - Next state is unconditionally IDLE.
- Latency and throughput:
  - Word accepted at edge k: first bit is visible from cycle k+1.
  - With s_ready held high, the last bit is accepted at edge k+N, done is high in cycle k+N+1, and load_ready is high again in cycle k+N+2.
  - Minimum period per word is N+2 cycles.
- Width rules:
  - cnt is $clog2(N) bits and never exceeds N-1.
  - shift_reg is exactly N bits; no bits beyond N are ever transmitted.
- Boundary conditions:
  - load_valid while in SHIFT/DONE: ignored (load_ready=0); D is not sampled.
  - load_valid and s_ready both high in IDLE: only the load takes effect.
  - s_ready low indefinitely: the block holds in SHIFT with stable s_data/s_valid.
  - s_ready toggling mid-word: a bit is consumed only on edges where s_valid=1 and s_ready=1.
  - D changing during SHIFT: no effect on the bits already in flight.
  - Reset asserted mid-word: the word is discarded immediately and asynchronously, all outputs take their reset values, and no done pulse is issued.
  - Outputs are derived only from registered state. No output is combinationally dependent on D, load_valid or s_ready.

Decomposition:
- Package serializer_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t.
  - Constant SER_DEFAULT_N = 8.
- One natural sub-module, bit_counter:
  - Parameter N.
  - Ports: clk, rst (active-low async), clr, en, cnt, last.
  - last = (cnt==N-1).
- The shift register and the FSM stay in the top module.

Test Plan (N=8, 10-unit clock, s_ready=1 unless stated):
1. Reset: hold rst=0 for 2 cycles, driving load_valid=1 and D=8'hFF -> load_ready=1, s_valid=0, s_data=0, busy=0, done=0 throughout; no word captured.
2. Basic MSB-first: load D=8'hA5 -> s_data sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles with s_valid=1; done pulses for one cycle; load_ready is back to 1 two cycles after the last bit.
3. LSB-first (MSB_FIRST=0): load D=8'h0F -> sequence 1,1,1,1,0,0,0,0, then a done pulse.
4. Backpressure: load 8'h55 and drop s_ready for 3 cycles after bit 2 -> s_data holds bit 2's value (1) and s_valid stays 1; the remaining sequence resumes unchanged; total 8 bits; done fires once.
5. Load during busy: start 8'hF0, then present load_valid=1 with D=8'h0F mid-word -> 8'hF0 is transmitted intact; 8'h0F is accepted only after the block returns to IDLE.
6. Reset mid-word: load 8'hAA and assert rst=0 after 3 bits -> outputs go to reset values immediately with no done pulse; after release, load 8'h0F and the full correct sequence is sent.

Source files
------------

// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared types and constants for the PISO serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Default word width
    localparam int SER_DEFAULT_N = 8;

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter
// Description : Counts accepted serial bits of one word; flags the last bit.
//               Saturates at N-1 so the count never leaves the word range.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
    import serializer_pkg::*;
#(
    parameter  int N  = SER_DEFAULT_N,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    // Clear on a new word, advance on each accepted bit, hold at the last bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == c_LAST);

endmodule : bit_counter
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out transmitter. Captures an N-bit word on
//               a load handshake and emits it one bit per accepted cycle on a
//               valid/ready serial port, then pulses done for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int N         = SER_DEFAULT_N,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         s_data,
    output logic         s_valid,
    input  logic         s_ready,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    ser_state_t    r_state;
    ser_state_t    w_state_next;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  w_shifted;
    logic          w_out_bit;
    logic          w_load_acc;
    logic          w_bit_acc;
    logic          w_last;
    logic [CW-1:0] w_cnt_unused;   // progress is consumed through w_last only

    assign w_load_acc = (r_state == IDLE)  && load_valid;
    assign w_bit_acc  = (r_state == SHIFT) && s_ready;

    // Output end of the shift register and the zero-filled shifted word
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit = r_shift[N-1];
            assign w_shifted = {r_shift[N-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit = r_shift[0];
            assign w_shifted = {1'b0, r_shift[N-1:1]};
        end
    endgenerate

    bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load_acc),
        .en   (w_bit_acc),
        .cnt  (w_cnt_unused),
        .last (w_last)
    );

    // Shift register: capture on load, advance only on an accepted bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (w_load_acc) begin
            r_shift <= D;
        end else if (w_bit_acc) begin
            r_shift <= w_shifted;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and outputs; outputs depend only on registered state
    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        s_valid      = 1'b0;
        s_data       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                s_valid = 1'b1;
                s_data  = w_out_bit;
                busy    = 1'b1;
                if (s_ready && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : piso_serializer
`default_nettype wire
